// File: rtl/keypad_bcd_entry.sv
`timescale 1ns/1ps
// Scans a 4x4 keypad column by column, debounces whole frames and builds a packed-BCD entry value.
// Accept lands >= DEBOUNCE_SCANS frames + 3 clk after a press; no backpressure, key_valid is a bare pulse.
module keypad_bcd_entry #(
    parameter int SCAN_TICKS     = 6250,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DIGITS         = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          row_n,
    output logic [3:0]          col_n,
    output logic                key_valid,
    output logic [3:0]          key_code,
    output logic                enter,
    output logic [4*DIGITS-1:0] value
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    typedef enum logic {IDLE, HELD} state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] tick;
    logic [1:0]    col_idx;
    logic [15:0]   frame;
    logic          frame_done;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] count;
    logic [4:0]    n_keys;
    logic [3:0]    hit;
    logic [3:0]    hit_code;
    logic          frame_none;
    logic          frame_single;
    logic [CW-1:0] idle_cnt_next;

    // Frame bit index is {column, row}; returns the legend printed on that key.
    function automatic logic [3:0] key_map(input logic [3:0] pos);
        case (pos)
            4'd0:  key_map = 4'h1;
            4'd1:  key_map = 4'h4;
            4'd2:  key_map = 4'h7;
            4'd3:  key_map = 4'h0;
            4'd4:  key_map = 4'h2;
            4'd5:  key_map = 4'h5;
            4'd6:  key_map = 4'h8;
            4'd7:  key_map = 4'hF;
            4'd8:  key_map = 4'h3;
            4'd9:  key_map = 4'h6;
            4'd10: key_map = 4'h9;
            4'd11: key_map = 4'hE;
            4'd12: key_map = 4'hA;
            4'd13: key_map = 4'hB;
            4'd14: key_map = 4'hC;
            default: key_map = 4'hD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Sampling on the last tick leaves the synchronizer a full cycle of settled column drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick       <= '0;
            col_idx    <= 2'd0;
            col_n      <= 4'b1110;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick == TICK_LAST) begin
                tick                          <= '0;
                frame[{col_idx, 2'b00} +: 4] <= ~row_sync;
                col_idx                       <= col_idx + 2'd1;
                col_n                         <= {col_n[2:0], col_n[3]};
                frame_done                    <= (col_idx == 2'd3);
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    always_comb begin
        n_keys = 5'd0;
        hit    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame[i]) begin
                n_keys = n_keys + 5'd1;
                hit    = 4'(i);
            end
        end
        hit_code      = key_map(hit);
        frame_none    = (n_keys == 5'd0);
        frame_single  = (n_keys == 5'd1);
        idle_cnt_next = (hit_code == cand) ? count + 1'b1 : CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 4'h0;
            count     <= '0;
            key_valid <= 1'b0;
            enter     <= 1'b0;
            key_code  <= 4'h0;
            value     <= '0;
        end else begin
            key_valid <= 1'b0;
            enter     <= 1'b0;
            if (frame_done) begin
                case (state)
                    IDLE: begin
                        if (frame_single) begin
                            cand <= hit_code;
                            if (idle_cnt_next >= CNT_DONE) begin
                                state     <= HELD;
                                count     <= '0;
                                key_valid <= 1'b1;
                                key_code  <= hit_code;
                                enter     <= (hit_code == 4'hF);
                                if (hit_code <= 4'd9)
                                    value <= {value[4*DIGITS-5:0], hit_code};
                                else if (hit_code == 4'hA)
                                    value <= {4'h0, value[4*DIGITS-1:4]};
                                else if (hit_code == 4'hC)
                                    value <= '0;
                            end else begin
                                count <= idle_cnt_next;
                            end
                        end else begin
                            count <= '0;
                        end
                    end
                    HELD: begin
                        if (frame_none) begin
                            if (count + 1'b1 >= CNT_DONE) begin
                                state <= IDLE;
                                count <= '0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end else begin
                            count <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_bcd_entry.sv
`timescale 1ns/1ps
// Directed bench for keypad_bcd_entry with a behavioural keypad matrix driving row_n from col_n.
module tb_keypad_bcd_entry;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        enter;
    logic [31:0] value;

    logic [15:0] pressed = '0;   // index r*4+c
    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int enters = 0;
    int bad_enter = 0;
    logic [3:0]  last_code = 4'h0;
    logic [31:0] last_value = '0;

    keypad_bcd_entry #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2), .DIGITS(8)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_code(key_code), .enter(enter), .value(value)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            last_code  = key_code;
            last_value = value;
            if (enter) enters++;
        end else if (enter) begin
            bad_enter++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic frames(input int n);
        repeat (n*16) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that starts a new frame on column 0.
    task automatic align();
        int k;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (col_n !== 4'b0111 && k < 64);
        do begin @(posedge clk); #1; k++; end while (col_n !== 4'b1110 && k < 128);
        if (k >= 128) begin
            tests++; fails++;
            $display("FAIL align_timeout: col_n=%b expected 1110 within budget", col_n);
        end
    endtask

    task automatic press_key(input int r, input int c);
        align();
        pressed[r*4+c] = 1'b1;
        frames(3);
        pressed[r*4+c] = 1'b0;
        frames(3);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        tests++; if (enter !== 1'b0) begin fails++; $display("FAIL reset_enter: got %b expected 0", enter); end
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        tests++; if (value !== 32'h0) begin fails++; $display("FAIL reset_value: got %h expected 00000000", value); end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_col = 4'b1110;
            if (i >= 4)  exp_col = 4'b1101;
            if (i >= 8)  exp_col = 4'b1011;
            if (i >= 12) exp_col = 4'b0111;
            tests++;
            if (col_n !== exp_col) begin fails++; $display("FAIL col_scan[%0d]: got %b expected %b", i, col_n, exp_col); end
            @(posedge clk); #1;
        end
        frames(4);
        tests++; if (pulses !== 0) begin fails++; $display("FAIL idle_no_pulse: got %0d pulses expected 0", pulses); end
        tests++; if (value !== 32'h0) begin fails++; $display("FAIL idle_value: got %h expected 00000000", value); end
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        align();
        pressed[1*4+1] = 1'b1;
        frames(10);
        pressed[1*4+1] = 1'b0;
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL hold5_pulses: got %0d expected 1", pulses - p0); end
        tests++; if (last_code !== 4'h5) begin fails++; $display("FAIL hold5_code: got %h expected 5", last_code); end
        tests++; if (last_value !== 32'h5) begin fails++; $display("FAIL hold5_value_at_pulse: got %h expected 00000005", last_value); end
        frames(2);
        pressed[2*4+0] = 1'b1;
        frames(3);
        pressed[2*4+0] = 1'b0;
        frames(3);
        tests++; if (pulses - p0 !== 2) begin fails++; $display("FAIL press7_pulses: got %0d expected 2", pulses - p0); end
        tests++; if (key_code !== 4'h7) begin fails++; $display("FAIL press7_code: got %h expected 7", key_code); end
        tests++; if (value !== 32'h57) begin fails++; $display("FAIL press7_value: got %h expected 00000057", value); end
    endtask

    task automatic test_digit_entry();
        int p0;
        p0 = pulses;
        for (int d = 1; d <= 9; d++) press_key((d-1)/3, (d-1)%3);
        tests++; if (pulses - p0 !== 9) begin fails++; $display("FAIL digits_pulses: got %0d expected 9", pulses - p0); end
        tests++; if (value !== 32'h23456789) begin fails++; $display("FAIL digits_value: got %h expected 23456789", value); end
        press_key(0, 3);
        tests++; if (key_code !== 4'hA) begin fails++; $display("FAIL backspace_code: got %h expected a", key_code); end
        tests++; if (value !== 32'h02345678) begin fails++; $display("FAIL backspace_value: got %h expected 02345678", value); end
        press_key(2, 3);
        tests++; if (key_code !== 4'hC) begin fails++; $display("FAIL clear_code: got %h expected c", key_code); end
        tests++; if (value !== 32'h0) begin fails++; $display("FAIL clear_value: got %h expected 00000000", value); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        align();
        repeat (3) begin
            pressed[0*4+2] = 1'b1;
            frames(1);
            pressed[0*4+2] = 1'b0;
            frames(1);
        end
        tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL bounce_no_pulse: got %0d expected 0", pulses - p0); end
        pressed[0*4+2] = 1'b1;
        frames(3);
        pressed[0*4+2] = 1'b0;
        frames(3);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL bounce_steady_pulses: got %0d expected 1", pulses - p0); end
        tests++; if (last_code !== 4'h3) begin fails++; $display("FAIL bounce_code: got %h expected 3", last_code); end
        tests++; if (value !== 32'h3) begin fails++; $display("FAIL bounce_value: got %h expected 00000003", value); end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses;
        align();
        pressed[0*4+0] = 1'b1;
        pressed[1*4+0] = 1'b1;
        frames(4);
        tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL multi_no_pulse: got %0d expected 0", pulses - p0); end
        pressed[1*4+0] = 1'b0;
        frames(3);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL multi_release_pulses: got %0d expected 1", pulses - p0); end
        tests++; if (last_code !== 4'h1) begin fails++; $display("FAIL multi_release_code: got %h expected 1", last_code); end
        tests++; if (value !== 32'h31) begin fails++; $display("FAIL multi_release_value: got %h expected 00000031", value); end
        pressed[0*4+0] = 1'b0;
        frames(3);
    endtask

    task automatic test_enter_reset();
        int p0, e0;
        p0 = pulses;
        e0 = enters;
        align();
        pressed[3*4+1] = 1'b1;
        frames(3);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL enter_pulses: got %0d expected 1", pulses - p0); end
        tests++; if (enters - e0 !== 1) begin fails++; $display("FAIL enter_coincident: got %0d expected 1", enters - e0); end
        tests++; if (last_code !== 4'hF) begin fails++; $display("FAIL enter_code: got %h expected f", last_code); end
        tests++; if (value !== 32'h31) begin fails++; $display("FAIL enter_value: got %h expected 00000031", value); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (key_code !== 4'h0) begin fails++; $display("FAIL midreset_code: got %h expected 0", key_code); end
        tests++; if (value !== 32'h0) begin fails++; $display("FAIL midreset_value: got %h expected 00000000", value); end
        tests++; if (col_n !== 4'b1110) begin fails++; $display("FAIL midreset_col: got %b expected 1110", col_n); end
        p0 = pulses;
        e0 = enters;
        reset = 1'b0;
        frames(6);
        tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses - p0); end
        tests++; if (enters - e0 !== 1) begin fails++; $display("FAIL post_reset_enter: got %0d expected 1", enters - e0); end
        tests++; if (key_code !== 4'hF) begin fails++; $display("FAIL post_reset_code: got %h expected f", key_code); end
        tests++; if (value !== 32'h0) begin fails++; $display("FAIL post_reset_value: got %h expected 00000000", value); end
        pressed[3*4+1] = 1'b0;
        frames(3);
        tests++; if (bad_enter !== 0) begin fails++; $display("FAIL enter_without_valid: got %0d expected 0", bad_enter); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_digit_entry();
        test_bounce();
        test_multi();
        test_enter_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
